// File: rtl/ddr_ahb_csr_bank.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_ahb_csr_bank
//  Purpose  : AHB-Lite slave with NUM_CFG read/write config words and NUM_STA
//             read-only status words. Supports byte-lane writes, ERROR
//             responses for unmapped or illegal accesses, and per-word
//             write-commit pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_ahb_csr_bank #(
  parameter int                            AWIDTH  = 32,
  parameter int                            DWIDTH  = 32,
  parameter int                            NUM_CFG = 8,
  parameter int                            NUM_STA = 2,
  parameter logic [NUM_CFG*DWIDTH-1:0]     CFG_RST = '0
) (
  input  logic                                        i_hclk,
  input  logic                                        i_hreset,
  input  logic [AWIDTH-1:0]                           i_haddr,
  input  logic                                        i_hwrite,
  input  logic                                        i_hsel,
  input  logic [DWIDTH-1:0]                           i_hwdata,
  input  logic [1:0]                                  i_htrans,
  input  logic [2:0]                                  i_hsize,
  input  logic [2:0]                                  i_hburst,
  input  logic                                        i_hreadyin,
  output logic                                        o_hready,
  output logic [DWIDTH-1:0]                           o_hrdata,
  output logic [1:0]                                  o_hresp,
  output logic [NUM_CFG*DWIDTH-1:0]                   o_cfg,
  output logic [NUM_CFG-1:0]                          o_cfg_wr_pulse,
  input  logic [((NUM_STA > 0) ? NUM_STA : 1)*DWIDTH-1:0] i_sta
);

  localparam int c_NUM_WORDS = NUM_CFG + NUM_STA;
  localparam int c_IDXW      = (c_NUM_WORDS > 1) ? $clog2(c_NUM_WORDS) : 1;

  // The byte-lane logic assumes four 8-bit lanes; reject other data widths.
  if (DWIDTH != 32) begin : g_dwidth_check
    $error("ddr_ahb_csr_bank: DWIDTH must be 32");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t                    state_q;
  logic                      hready_q;
  logic                      hresp_q;
  logic [c_IDXW-1:0]         idx_q;
  logic                      write_q;
  logic [3:0]                mask_q;
  logic [NUM_CFG*DWIDTH-1:0] cfg_q;
  logic [NUM_CFG-1:0]        pulse_q;

  logic                      w_accept;
  logic                      w_legal;
  logic [3:0]                w_mask;
  logic [AWIDTH-1:0]         w_word;
  logic                      w_unused;

  // Burst type and the SEQ/NONSEQ distinction carry no meaning here.
  assign w_unused = ^{i_hburst, i_htrans[0]};

  assign w_accept = i_hsel & i_hreadyin & i_htrans[1] & hready_q;
  assign w_word   = {2'b00, i_haddr[AWIDTH-1:2]};

  // Address-phase decode: byte-lane mask and legality of the access.
  always_comb begin
    w_mask = 4'hF;
    case (i_hsize)
      3'd0:    w_mask = 4'b0001 << i_haddr[1:0];
      3'd1:    w_mask = 4'b0011 << i_haddr[1:0];
      default: w_mask = 4'hF;
    endcase
    w_legal = 1'b1;
    if (w_word >= AWIDTH'(c_NUM_WORDS))                w_legal = 1'b0;
    if (i_hsize > 3'd2)                                w_legal = 1'b0;
    if ((i_hsize == 3'd1) && i_haddr[0])               w_legal = 1'b0;
    if ((i_hsize == 3'd2) && (i_haddr[1:0] != 2'b00))  w_legal = 1'b0;
    if (i_hwrite && (w_word >= AWIDTH'(NUM_CFG)))      w_legal = 1'b0;
  end

  // Transfer FSM with registered HREADY/HRESP; captures the address phase on accept.
  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      state_q  <= S_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      mask_q   <= '0;
    end else begin
      if (w_accept) begin
        idx_q   <= i_haddr[c_IDXW+1:2];
        write_q <= i_hwrite;
        mask_q  <= w_mask;
      end
      case (state_q)
        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          if (w_accept && w_legal) begin
            state_q  <= S_DATA;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end else if (w_accept) begin
            state_q  <= S_ERR1;
            hready_q <= 1'b0;
            hresp_q  <= 1'b1;
          end else begin
            state_q  <= S_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Commit write data lane by lane at the end of a write data phase and pulse that word.
  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      cfg_q   <= CFG_RST;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if ((state_q == S_DATA) && write_q) begin
        for (int k = 0; k < NUM_CFG; k++) begin
          if (idx_q == c_IDXW'(k)) begin
            pulse_q[k] <= 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (mask_q[b]) begin
                cfg_q[k*DWIDTH + b*8 +: 8] <= i_hwdata[b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  // Read mux driven from the registered index; zero outside a read data phase.
  always_comb begin
    o_hrdata = '0;
    if ((state_q == S_DATA) && !write_q) begin
      for (int k = 0; k < NUM_CFG; k++) begin
        if (idx_q == c_IDXW'(k)) o_hrdata = cfg_q[k*DWIDTH +: DWIDTH];
      end
      for (int k = 0; k < NUM_STA; k++) begin
        if (idx_q == c_IDXW'(NUM_CFG + k)) o_hrdata = i_sta[k*DWIDTH +: DWIDTH];
      end
    end
  end

  assign o_hready       = hready_q;
  assign o_hresp        = {1'b0, hresp_q};
  assign o_cfg          = cfg_q;
  assign o_cfg_wr_pulse = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_ahb_csr_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_ahb_csr_bank
//  Purpose  : Directed self-checking bench for ddr_ahb_csr_bank.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_ahb_csr_bank;

  localparam int          NUM_CFG = 8;
  localparam int          NUM_STA = 2;
  localparam logic [255:0] CFG_RST = {224'h0, 32'hA5A5_0001};

  logic          clk;
  logic          rst_n;
  logic [31:0]   haddr;
  logic          hwrite;
  logic          hsel;
  logic [31:0]   hwdata;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          hready;
  logic [31:0]   hrdata;
  logic [1:0]    hresp;
  logic [255:0]  cfg;
  logic [7:0]    pulse;
  logic [63:0]   sta;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd;
  logic        r1, r2;
  logic [1:0]  e1, e2;
  logic [7:0]  p2;

  ddr_ahb_csr_bank #(
    .AWIDTH (32),
    .DWIDTH (32),
    .NUM_CFG(NUM_CFG),
    .NUM_STA(NUM_STA),
    .CFG_RST(CFG_RST)
  ) dut (
    .i_hclk        (clk),
    .i_hreset      (rst_n),
    .i_haddr       (haddr),
    .i_hwrite      (hwrite),
    .i_hsel        (hsel),
    .i_hwdata      (hwdata),
    .i_htrans      (htrans),
    .i_hsize       (hsize),
    .i_hburst      (3'd0),
    .i_hreadyin    (1'b1),
    .o_hready      (hready),
    .o_hrdata      (hrdata),
    .o_hresp       (hresp),
    .o_cfg         (cfg),
    .o_cfg_wr_pulse(pulse),
    .i_sta         (sta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated transfer: address phase, then two sampled cycles.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] o_rd,
                      output logic o_r1, output logic [1:0] o_e1,
                      output logic o_r2, output logic [1:0] o_e2,
                      output logic [7:0] o_p2);
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
    @(negedge clk);
    htrans = 2'b00; hwdata = wd;
    o_rd = hrdata; o_r1 = hready; o_e1 = hresp;
    @(negedge clk);
    o_r2 = hready; o_e2 = hresp; o_p2 = pulse;
  endtask

  initial begin
    rst_n = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
    hsize = 3'd2; hwdata = '0; sta = {32'h0, 32'h0000_1234};
    repeat (3) @(negedge clk);

    // 1. Reset state
    chk("rst_cfg0",   cfg[31:0], 32'hA5A5_0001);
    chk("rst_cfg1",   cfg[63:32], 32'h0);
    chk("rst_hready", {31'b0, hready}, 32'd1);
    chk("rst_hresp",  {30'b0, hresp}, 32'd0);
    chk("rst_pulse",  {24'b0, pulse}, 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    rst_n = 1'b1;

    // 2. Word write to 0x04, then back-to-back read of 0x04
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h04; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    chk("wr_hready", {31'b0, hready}, 32'd1);
    chk("wr_hresp",  {30'b0, hresp}, 32'd0);
    chk("wr_cfg1_pre", cfg[63:32], 32'h0);
    hwdata = 32'hDEAD_BEEF; htrans = 2'b10; haddr = 32'h04; hwrite = 1'b0;
    @(negedge clk);
    htrans = 2'b00;
    chk("wr_cfg1",     cfg[63:32], 32'hDEAD_BEEF);
    chk("wr_pulse",    {24'b0, pulse}, 32'h02);
    chk("rd_b2b_data", hrdata, 32'hDEAD_BEEF);
    chk("rd_b2b_rdy",  {31'b0, hready}, 32'd1);
    @(negedge clk);
    chk("pulse_once",  {24'b0, pulse}, 32'd0);
    chk("rdata_idle",  hrdata, 32'd0);

    // 3. Byte write over zero, then misaligned half write
    xfer(32'h04, 1'b1, 3'd2, 32'h0, rd, r1, e1, r2, e2, p2);
    chk("clr_cfg1", cfg[63:32], 32'h0);
    xfer(32'h06, 1'b1, 3'd0, 32'h0077_0000, rd, r1, e1, r2, e2, p2);
    chk("byte_cfg1",  cfg[63:32], 32'h0077_0000);
    chk("byte_resp",  {30'b0, e1}, 32'd0);
    chk("byte_pulse", {24'b0, p2}, 32'h02);
    xfer(32'h05, 1'b1, 3'd1, 32'hFFFF_FFFF, rd, r1, e1, r2, e2, p2);
    chk("mis_rdy1",  {31'b0, r1}, 32'd0);
    chk("mis_resp1", {30'b0, e1}, 32'd1);
    chk("mis_rdy2",  {31'b0, r2}, 32'd1);
    chk("mis_resp2", {30'b0, e2}, 32'd1);
    chk("mis_pulse", {24'b0, p2}, 32'd0);
    chk("mis_cfg1",  cfg[63:32], 32'h0077_0000);

    // 4. Status read and illegal status write
    xfer(32'h20, 1'b0, 3'd2, 32'h0, rd, r1, e1, r2, e2, p2);
    chk("sta_rdata", rd, 32'h0000_1234);
    chk("sta_resp",  {30'b0, e1}, 32'd0);
    chk("sta_rdy",   {31'b0, r1}, 32'd1);
    xfer(32'h20, 1'b1, 3'd2, 32'hCAFE_F00D, rd, r1, e1, r2, e2, p2);
    chk("staw_rdy1",  {31'b0, r1}, 32'd0);
    chk("staw_resp1", {30'b0, e1}, 32'd1);
    chk("staw_rdy2",  {31'b0, r2}, 32'd1);
    chk("staw_resp2", {30'b0, e2}, 32'd1);
    chk("staw_pulse", {24'b0, p2}, 32'd0);

    // 5. Out-of-range index, then pipelined read of 0x00 in ERR2
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h28; hwrite = 1'b0; hsize = 3'd2;
    @(negedge clk);
    htrans = 2'b00;
    chk("oor_rdy1",  {31'b0, hready}, 32'd0);
    chk("oor_resp1", {30'b0, hresp}, 32'd1);
    @(negedge clk);
    chk("oor_rdy2",  {31'b0, hready}, 32'd1);
    chk("oor_resp2", {30'b0, hresp}, 32'd1);
    htrans = 2'b10; haddr = 32'h00; hwrite = 1'b0;
    @(negedge clk);
    htrans = 2'b00;
    chk("pipe_rdata", hrdata, 32'hA5A5_0001);
    chk("pipe_resp",  {30'b0, hresp}, 32'd0);
    chk("pipe_rdy",   {31'b0, hready}, 32'd1);

    // Unselected transfer has no effect
    xfer(32'h00, 1'b1, 3'd2, 32'h1111_1111, rd, r1, e1, r2, e2, p2);
    chk("sel_cfg0", cfg[31:0], 32'h1111_1111);
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1;
    @(negedge clk);
    htrans = 2'b00; hwdata = 32'h9999_9999;
    @(negedge clk);
    chk("nosel_pulse", {24'b0, pulse}, 32'd0);
    chk("nosel_cfg4",  cfg[159:128], 32'h0);

    // 6. Reset asserted during a write data phase
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h08; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    #2 rst_n = 1'b0;
    #1 chk("arst_cfg1", cfg[63:32], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NUM_CFG; k++)
      chk($sformatf("arst_cfg%0d", k), cfg[k*32 +: 32], CFG_RST[k*32 +: 32]);
    chk("arst_pulse",  {24'b0, pulse}, 32'd0);
    chk("arst_hready", {31'b0, hready}, 32'd1);
    xfer(32'h0C, 1'b1, 3'd2, 32'h0000_0055, rd, r1, e1, r2, e2, p2);
    chk("post_resp",  {30'b0, e1}, 32'd0);
    chk("post_cfg3",  cfg[127:96], 32'h0000_0055);
    chk("post_pulse", {24'b0, p2}, 32'h08);
    xfer(32'h0E, 1'b1, 3'd1, 32'hBEEF_0000, rd, r1, e1, r2, e2, p2);
    chk("half_cfg3",  cfg[127:96], 32'hBEEF_0055);
    chk("half_resp",  {30'b0, e1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
